// File: rtl/edf_irq_bridge.sv
// Core-side bridge for the EDF interrupt controller: latches the earliest-deadline winner,
// runs a req/ack/done handshake with the core, and counts deadline misses.
module edf_irq_bridge #(
  parameter int unsigned NrParIrqs = 4,
  parameter int unsigned CntWidth  = 16,
  localparam int unsigned IdWidth  = (NrParIrqs > 1) ? $clog2(NrParIrqs) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [63:0]         mtime_i,
  input  logic                pq_valid_i,
  input  logic [IdWidth-1:0]  pq_id_i,
  input  logic [63:0]         pq_deadline_i,
  output logic                irq_req_o,
  output logic [IdWidth-1:0]  irq_id_o,
  input  logic                irq_ack_i,
  input  logic [IdWidth-1:0]  irq_ack_id_i,
  input  logic                irq_done_i,
  output logic                clr_valid_o,
  output logic [IdWidth-1:0]  clr_id_o,
  output logic                ack_err_o,
  output logic                miss_o,
  output logic [CntWidth-1:0] miss_cnt_o
);

  typedef enum logic [1:0] {StIdle, StReq, StClr, StActive} state_e;

  localparam logic [CntWidth-1:0] CntMax = '1;

  state_e             state;
  logic [IdWidth-1:0] lat_id;
  logic [63:0]        lat_dl;
  logic               miss_flag;
  logic               miss_now;

  // At most one miss per latched winner; the flag is re-armed on every new latch.
  assign miss_now = ((state == StReq) || (state == StActive)) && !miss_flag &&
                    (mtime_i > lat_dl);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= StIdle;
      lat_id      <= '0;
      lat_dl      <= '0;
      miss_flag   <= 1'b0;
      irq_req_o   <= 1'b0;
      irq_id_o    <= '0;
      clr_valid_o <= 1'b0;
      clr_id_o    <= '0;
      ack_err_o   <= 1'b0;
      miss_o      <= 1'b0;
      miss_cnt_o  <= '0;
    end else begin
      clr_valid_o <= 1'b0;
      ack_err_o   <= 1'b0;
      miss_o      <= miss_now;
      if (miss_now) begin
        miss_flag <= 1'b1;
        if (miss_cnt_o != CntMax) miss_cnt_o <= miss_cnt_o + CntWidth'(1);
      end

      unique case (state)
        StIdle: begin
          irq_req_o <= 1'b0;
          if (pq_valid_i) begin
            lat_id    <= pq_id_i;
            lat_dl    <= pq_deadline_i;
            irq_id_o  <= pq_id_i;
            miss_flag <= 1'b0;
            irq_req_o <= 1'b1;
            state     <= StReq;
          end
        end
        StReq: begin
          if (irq_ack_i && (irq_ack_id_i == lat_id)) begin
            irq_req_o   <= 1'b0;
            clr_valid_o <= 1'b1;
            clr_id_o    <= lat_id;
            state       <= StClr;
          end else if (irq_ack_i) begin
            irq_req_o <= 1'b0;
            ack_err_o <= 1'b1;
            state     <= StIdle;
          end else if (!pq_valid_i) begin
            irq_req_o <= 1'b0;
            state     <= StIdle;
          end else if (pq_deadline_i < lat_dl) begin
            // Preemption: a strictly earlier deadline replaces the pending request.
            lat_id    <= pq_id_i;
            lat_dl    <= pq_deadline_i;
            irq_id_o  <= pq_id_i;
            miss_flag <= 1'b0;
          end
        end
        StClr: begin
          irq_req_o <= 1'b0;
          state     <= StActive;
        end
        StActive: begin
          irq_req_o <= 1'b0;
          if (irq_done_i) state <= StIdle;
        end
        default: begin
          irq_req_o <= 1'b0;
          state     <= StIdle;
        end
      endcase
    end
  end

endmodule
